// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared types, default constants and helpers for the ESC pulse transmitter
package esc_pkg;

  localparam int CLK_PER_US_DEF = 50;
  localparam int FRAME_US_DEF   = 20000;
  localparam int MIN_US_DEF     = 1000;
  localparam int RATIO_MAX_DEF  = 1000;
  localparam int ARM_FRAMES_DEF = 100;
  localparam int SLEW_STEP_DEF  = 20;

  localparam int RATIO_W = 11;
  localparam int WIDTH_W = 12;

  // Throttle ratio as produced by the stabiliser (0..1000 nominal).
  typedef logic [RATIO_W-1:0] ratio_t;
  // Pulse width in microseconds.
  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2
  } esc_state_t;

  function automatic ratio_t clamp_ratio(input ratio_t r, input ratio_t lim);
    return (r > lim) ? lim : r;
  endfunction

  // Move cur toward tgt by at most step, landing exactly on tgt when close.
  function automatic ratio_t slew_toward(input ratio_t cur, input ratio_t tgt, input ratio_t step);
    ratio_t res;
    if (tgt > cur) begin
      res = ((tgt - cur) > step) ? (cur + step) : tgt;
    end else begin
      res = ((cur - tgt) > step) ? (cur - step) : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/esc_pwm_tx_if.sv
// rtl/esc_pwm_tx_if.sv - ratio/arm inputs and pulse outputs of the ESC pulse transmitter
interface esc_pwm_tx_if;
  import esc_pkg::*;

  ratio_t m1ratio;
  ratio_t m2ratio;
  ratio_t m3ratio;
  ratio_t m4ratio;
  logic   arm_req;
  logic   pwm1;
  logic   pwm2;
  logic   pwm3;
  logic   pwm4;
  logic   frame_start;
  logic   armed;

  // Upstream controller side: supplies ratios and the arm request.
  modport master (
    output m1ratio, m2ratio, m3ratio, m4ratio, arm_req,
    input  pwm1, pwm2, pwm3, pwm4, frame_start, armed
  );

  // Transmitter side.
  modport slave (
    input  m1ratio, m2ratio, m3ratio, m4ratio, arm_req,
    output pwm1, pwm2, pwm3, pwm4, frame_start, armed
  );

endinterface

// File: rtl/esc_pwm_channel.sv
// rtl/esc_pwm_channel.sv - one ESC channel: clamp, optional slew (ESC_SLEW_LIMIT_EN), shadow and compare
module esc_pwm_channel
  import esc_pkg::*;
#(
  parameter int MIN_US    = MIN_US_DEF,
  parameter int RATIO_MAX = RATIO_MAX_DEF,
  parameter int SLEW_STEP = SLEW_STEP_DEF,
  parameter int FW        = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boundary_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [FW-1:0] frame_us_i,
  input  ratio_t        ratio_i,
  output logic          pwm_o
);

  localparam ratio_t RMAX = ratio_t'(RATIO_MAX);

  ratio_t target;
  ratio_t sh_q;
  ratio_t sh_d;
  width_t width;
  logic   pwm_q;
  logic   pwm_d;

  assign target = clamp_ratio(ratio_i, RMAX);
  assign width  = width_t'(MIN_US) + width_t'(sh_q);

`ifdef ESC_SLEW_LIMIT_EN
  localparam ratio_t STEP = ratio_t'(SLEW_STEP);

  // Shadow only moves at a frame boundary; outside ARMED it is held at zero.
  always_comb begin
    sh_d = sh_q;
    if (boundary_i) begin
      if (load_i) begin
        sh_d = slew_toward(sh_q, target, STEP);
      end else begin
        sh_d = '0;
      end
    end
  end
`else
  // Shadow only moves at a frame boundary; outside ARMED it is held at zero.
  always_comb begin
    sh_d = sh_q;
    if (boundary_i) begin
      if (load_i) begin
        sh_d = target;
      end else begin
        sh_d = '0;
      end
    end
  end
`endif

  // Pulse is high from the frame wrap until the count reaches the latched width.
  always_comb begin
    pwm_d = en_i && (32'(frame_us_i) < 32'(width));
  end

  // Shadow ratio and registered pulse output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_tx.sv
// rtl/esc_pwm_tx.sv - four-channel 50 Hz ESC pulse transmitter with arming sequencer (option ESC_SLEW_LIMIT_EN)
module esc_pwm_tx
  import esc_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int FRAME_US   = FRAME_US_DEF,
  parameter int MIN_US     = MIN_US_DEF,
  parameter int RATIO_MAX  = RATIO_MAX_DEF,
  parameter int ARM_FRAMES = ARM_FRAMES_DEF,
  parameter int SLEW_STEP  = SLEW_STEP_DEF
) (
  input logic           clk,
  input logic           rst,
  esc_pwm_tx_if.slave   bus_if
);

  localparam int FW = $clog2(FRAME_US);
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int AW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [FW-1:0] frame_us_q;
  logic [FW-1:0] frame_us_d;
  logic          frame_start_q;
  logic          frame_start_d;
  esc_state_t    state_q;
  esc_state_t    state_d;
  logic [AW-1:0] arm_cnt_q;
  logic [AW-1:0] arm_cnt_d;
  logic          armed_q;
  logic          armed_d;

  logic us_tick;
  logic boundary;
  logic ch_en;
  logic ch_load;

  assign us_tick  = (presc_q == PW'(CLK_PER_US - 1));
  assign boundary = us_tick && (frame_us_q == FW'(FRAME_US - 1));

  // Microsecond prescaler and frame position counter.
  always_comb begin
    presc_d       = us_tick ? '0 : presc_q + 1'b1;
    frame_us_d    = frame_us_q;
    frame_start_d = boundary;
    if (us_tick) begin
      frame_us_d = boundary ? '0 : frame_us_q + 1'b1;
    end
  end

  // Arming sequencer: arm_req is only looked at on a frame boundary.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (boundary) begin
      case (state_q)
        DISARMED: begin
          if (bus_if.arm_req) begin
            state_d   = ARMING;
            arm_cnt_d = '0;
          end
        end
        ARMING: begin
          arm_cnt_d = arm_cnt_q + 1'b1;
          if (!bus_if.arm_req) begin
            state_d = DISARMED;
          end else if (arm_cnt_q == AW'(ARM_FRAMES - 1)) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (!bus_if.arm_req) begin
            state_d = DISARMED;
          end
        end
        default: begin
          state_d = DISARMED;
        end
      endcase
    end
    armed_d = (state_d == ARMED);
  end

  // Timing and sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      frame_us_q    <= '0;
      frame_start_q <= 1'b0;
      state_q       <= DISARMED;
      arm_cnt_q     <= '0;
      armed_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      frame_us_q    <= frame_us_d;
      frame_start_q <= frame_start_d;
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      armed_q       <= armed_d;
    end
  end

  // Pulses are enabled for the frame the state machine is currently in;
  // shadows load live ratios only for frames that will run ARMED.
  assign ch_en   = (state_q != DISARMED);
  assign ch_load = (state_d == ARMED);

  esc_pwm_channel #(
    .MIN_US(MIN_US), .RATIO_MAX(RATIO_MAX), .SLEW_STEP(SLEW_STEP), .FW(FW)
  ) u_ch1 (
    .clk(clk), .rst(rst), .boundary_i(boundary), .load_i(ch_load), .en_i(ch_en),
    .frame_us_i(frame_us_q), .ratio_i(bus_if.m1ratio), .pwm_o(bus_if.pwm1)
  );

  esc_pwm_channel #(
    .MIN_US(MIN_US), .RATIO_MAX(RATIO_MAX), .SLEW_STEP(SLEW_STEP), .FW(FW)
  ) u_ch2 (
    .clk(clk), .rst(rst), .boundary_i(boundary), .load_i(ch_load), .en_i(ch_en),
    .frame_us_i(frame_us_q), .ratio_i(bus_if.m2ratio), .pwm_o(bus_if.pwm2)
  );

  esc_pwm_channel #(
    .MIN_US(MIN_US), .RATIO_MAX(RATIO_MAX), .SLEW_STEP(SLEW_STEP), .FW(FW)
  ) u_ch3 (
    .clk(clk), .rst(rst), .boundary_i(boundary), .load_i(ch_load), .en_i(ch_en),
    .frame_us_i(frame_us_q), .ratio_i(bus_if.m3ratio), .pwm_o(bus_if.pwm3)
  );

  esc_pwm_channel #(
    .MIN_US(MIN_US), .RATIO_MAX(RATIO_MAX), .SLEW_STEP(SLEW_STEP), .FW(FW)
  ) u_ch4 (
    .clk(clk), .rst(rst), .boundary_i(boundary), .load_i(ch_load), .en_i(ch_en),
    .frame_us_i(frame_us_q), .ratio_i(bus_if.m4ratio), .pwm_o(bus_if.pwm4)
  );

  assign bus_if.frame_start = frame_start_q;
  assign bus_if.armed       = armed_q;

endmodule

// File: tb/tb_esc_pwm_tx.sv
// tb/tb_esc_pwm_tx.sv - directed self-checking bench for esc_pwm_tx at reduced frame parameters
module tb_esc_pwm_tx;

  localparam int CPU        = 2;
  localparam int FUS        = 200;
  localparam int MINW       = 50;
  localparam int RMAX       = 100;
  localparam int ARMF       = 3;
  localparam int SLEW       = 20;
  localparam int FRAME_CLKS = CPU * FUS;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cur_m4;

  esc_pwm_tx_if esc_if ();

  esc_pwm_tx #(
    .CLK_PER_US(CPU), .FRAME_US(FUS), .MIN_US(MINW),
    .RATIO_MAX(RMAX), .ARM_FRAMES(ARMF), .SLEW_STEP(SLEW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_if(esc_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits for the next frame_start, then counts high cycles of each pwm over one frame.
  // chg_kind: 0 none, 1 set m1ratio, 2 set arm_req, 3 pulse arm_req for 10 clks.
  task automatic measure_frame(input int chg_at, input int chg_kind, input int chg_val,
                               output int c1, output int c2, output int c3, output int c4,
                               output logic arm_s, output logic p4_chg);
    int guard;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    arm_s = 1'b0; p4_chg = 1'b0; guard = 0;
    @(negedge clk);
    while (esc_if.frame_start !== 1'b1 && guard < 2 * FRAME_CLKS) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (esc_if.frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_start_timeout: frame_start=%b required 1", esc_if.frame_start);
    end
    arm_s = esc_if.armed;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      if (i > 0) @(negedge clk);
      if (esc_if.pwm1 === 1'b1) c1++;
      if (esc_if.pwm2 === 1'b1) c2++;
      if (esc_if.pwm3 === 1'b1) c3++;
      if (esc_if.pwm4 === 1'b1) c4++;
      if (i == chg_at) begin
        p4_chg = esc_if.pwm4;
        if (chg_kind == 1) esc_if.m1ratio = 11'(chg_val);
        if (chg_kind == 2 || chg_kind == 3) esc_if.arm_req = chg_val[0];
      end
      if (chg_kind == 3 && i == chg_at + 10) esc_if.arm_req = ~chg_val[0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    esc_if.m1ratio = '0; esc_if.m2ratio = '0; esc_if.m3ratio = '0; esc_if.m4ratio = '0;
    esc_if.arm_req = 1'b0;
    cur_m4 = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b required 000000",
               {esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start});
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start} !== 6'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got %b required 000000",
               {esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start});
    end
  endtask

  task automatic test_arming();
    int c1, c2, c3, c4;
    logic a, p;
    esc_if.arm_req = 1'b1;
    for (int f = 0; f < ARMF; f++) begin
      measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
      total++;
      if (c1 != CPU * MINW || c2 != CPU * MINW || c3 != CPU * MINW || c4 != CPU * MINW) begin
        bad++;
        $display("FAIL arming_width f%0d: got %0d/%0d/%0d/%0d required %0d", f, c1, c2, c3, c4, CPU * MINW);
      end
      total++;
      if (a !== 1'b0) begin
        bad++;
        $display("FAIL arming_armed f%0d: got %b required 0", f, a);
      end
    end
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (a !== 1'b1) begin
      bad++;
      $display("FAIL armed_rise: got %b required 1", a);
    end
    total++;
    if (c1 != CPU * MINW || c4 != CPU * MINW) begin
      bad++;
      $display("FAIL armed_zero_width: got %0d/%0d required %0d", c1, c4, CPU * MINW);
    end
  endtask

  task automatic test_width();
    int c1, c2, c3, c4;
    logic a, p;
    int got [4];
    int exp_a [4];
    int exp_b [4];
    exp_a = '{150, 100, 300, 300};
    exp_b = '{300, 300, 102, 220};
    esc_if.m1ratio = 11'd25; esc_if.m2ratio = 11'd0; esc_if.m3ratio = 11'd150; esc_if.m4ratio = 11'd100;
    cur_m4 = 100;
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    got = '{c1, c2, c3, c4};
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] != exp_a[k]) begin
        bad++;
        $display("FAIL width_a ch%0d: got %0d required %0d", k + 1, got[k], exp_a[k]);
      end
    end
    esc_if.m1ratio = 11'd100; esc_if.m2ratio = 11'd2047; esc_if.m3ratio = 11'd1; esc_if.m4ratio = 11'd60;
    cur_m4 = 60;
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    got = '{c1, c2, c3, c4};
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] != exp_b[k]) begin
        bad++;
        $display("FAIL width_b ch%0d: got %0d required %0d", k + 1, got[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_midframe();
    int c1, c2, c3, c4;
    logic a, p;
    esc_if.m1ratio = 11'd20;
    measure_frame(50, 1, 80, c1, c2, c3, c4, a, p);
    total++;
    if (c1 != 140) begin
      bad++;
      $display("FAIL midframe_current: got %0d required 140", c1);
    end
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (c1 != 260) begin
      bad++;
      $display("FAIL midframe_next: got %0d required 260", c1);
    end
  endtask

  task automatic test_slew();
    int c1, c2, c3, c4;
    logic a, p;
    int sh;
    esc_if.m1ratio = 11'd100;
    sh = 0;
    for (int f = 0; f < 6; f++) begin
      sh = (sh + SLEW > RMAX) ? RMAX : sh + SLEW;
      measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
      total++;
      if (c1 != CPU * (MINW + sh)) begin
        bad++;
        $display("FAIL slew f%0d: got %0d required %0d", f, c1, CPU * (MINW + sh));
      end
    end
  endtask

  task automatic test_disarm();
    int c1, c2, c3, c4;
    logic a, p;
    int exp4;
    exp4 = CPU * (MINW + ((cur_m4 > RMAX) ? RMAX : cur_m4));
    measure_frame(20, 2, 0, c1, c2, c3, c4, a, p);
    total++;
    if (p !== 1'b1) begin
      bad++;
      $display("FAIL disarm_pwm4_high: got %b required 1", p);
    end
    total++;
    if (c4 != exp4) begin
      bad++;
      $display("FAIL disarm_full_width: got %0d required %0d", c4, exp4);
    end
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (a !== 1'b0) begin
      bad++;
      $display("FAIL disarm_armed_fall: got %b required 0", a);
    end
    total++;
    if (c1 + c2 + c3 + c4 != 0) begin
      bad++;
      $display("FAIL disarm_no_pulse: got %0d/%0d/%0d/%0d required 0", c1, c2, c3, c4);
    end
  endtask

  task automatic test_arm_toggle();
    int c1, c2, c3, c4;
    logic a, p;
    measure_frame(100, 3, 1, c1, c2, c3, c4, a, p);
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (c1 + c2 + c3 + c4 != 0 || a !== 1'b0) begin
      bad++;
      $display("FAIL arm_toggle_ignored: got pulses %0d armed %b required 0/0", c1 + c2 + c3 + c4, a);
    end
  endtask

  task automatic test_reset_midpulse();
    int c1, c2, c3, c4;
    logic a, p;
    int guard;
    esc_if.arm_req = 1'b1;
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (c1 != CPU * MINW) begin
      bad++;
      $display("FAIL rearm_width: got %0d required %0d", c1, CPU * MINW);
    end
    guard = 0;
    @(negedge clk);
    while (esc_if.frame_start !== 1'b1 && guard < 2 * FRAME_CLKS) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    total++;
    if (esc_if.pwm1 !== 1'b1) begin
      bad++;
      $display("FAIL midpulse_setup: pwm1=%b required 1", esc_if.pwm1);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset: got %b required 000000",
               {esc_if.pwm1, esc_if.pwm2, esc_if.pwm3, esc_if.pwm4, esc_if.armed, esc_if.frame_start});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (esc_if.frame_start !== 1'b0 || esc_if.armed !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold c%0d: frame_start=%b armed=%b required 0/0", i, esc_if.frame_start, esc_if.armed);
      end
    end
    rst = 1'b1;
    measure_frame(-1, 0, 0, c1, c2, c3, c4, a, p);
    total++;
    if (c1 != CPU * MINW || a !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_arming: got %0d armed %b required %0d/0", c1, a, CPU * MINW);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arming();
`ifdef ESC_SLEW_LIMIT_EN
    test_slew();
`else
    test_width();
    test_midframe();
`endif
    test_disarm();
    test_arm_toggle();
    test_reset_midpulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esc_pwm_tx.md
Name: esc_pwm_tx

Overview:
- Four-channel ESC pulse transmitter; the downstream end of the motor-ratio path.
- Consumes the stabiliser's m1ratio..m4ratio (0..1000 throttle units) and drives standard 50 Hz servo/ESC pulses, 1000-2000 us wide.
- Includes an arming sequencer so ESCs see a minimum-throttle calibration period before live throttle is passed through.
- Ratios are sampled once per frame, so upstream glitches never truncate a pulse mid-frame.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond (50 MHz system clock).
- FRAME_US, 20000, frame period in us.
- MIN_US, 1000, pulse width at ratio 0.
- RATIO_MAX, 1000, ratio clamp ceiling; maximum pulse width = MIN_US+RATIO_MAX.
- ARM_FRAMES, 100, number of minimum-width frames sent before entering ARMED.
- SLEW_STEP, 20, maximum per-frame ratio change (used only with the optional feature).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- m1ratio, in, 11, motor 1 throttle ratio.
- m2ratio, in, 11, motor 2 throttle ratio.
- m3ratio, in, 11, motor 3 throttle ratio.
- m4ratio, in, 11, motor 4 throttle ratio.
- arm_req, in, 1, level request to arm (1) or disarm (0).
- pwm1, out, 1, ESC pulse, motor 1.
- pwm2, out, 1, ESC pulse, motor 2.
- pwm3, out, 1, ESC pulse, motor 3.
- pwm4, out, 1, ESC pulse, motor 4.
- frame_start, out, 1, single-clk strobe at each frame boundary.
- armed, out, 1, high while in the ARMED state.

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. While rst=0, pwm1..4=0, frame_start=0, armed=0, state=DISARMED, all counters=0, shadow ratios=0. Outputs go low immediately, including mid-pulse.
- Prescaler: counts 0..CLK_PER_US-1; us_tick is high for one clk on the wrap.
- Frame counter frame_us:
  - Width $clog2(FRAME_US); advances only on us_tick.
  - On us_tick with frame_us==FRAME_US-1: frame_us<=0, frame_start<=1 for exactly one clk.
  - The state update, arm-count update and shadow latch all occur on this same edge.
- Shadow latch at boundary:
  - sh_n <= min(mN_ratio, RATIO_MAX), 11-bit unsigned.
  - Ratio inputs are ignored at every other time; a mid-frame change takes effect at the next frame only.
- Pulse width w_n = MIN_US + sh_n (12-bit).
- Pulse output: pwmN is a registered compare, pwmN <= en_n && (frame_us < w_n). Rising edge follows the frame_us wrap by 1 clk.
- State machine (transitions only at frame boundaries):
  - DISARMED:
    - en=0, so no pulses.
    - arm_req=1 -> ARMING, arm_cnt<=0.
  - ARMING:
    - en=1, sh forced to 0, so pulses are MIN_US wide.
    - arm_cnt increments at each boundary.
    - arm_cnt==ARM_FRAMES-1 -> ARMED.
    - arm_req=0 -> DISARMED.
  - ARMED:
    - en=1, shadows taken from the ratio inputs.
    - armed=1, registered from the state.
    - arm_req=0 -> DISARMED.
- Disarm mid-frame: the current frame's pulses complete with their latched width. The next frame has no pulses; armed falls at the boundary.
- arm_req is sampled only at boundaries; toggling within a frame has no effect.
- Ratio input exactly RATIO_MAX gives a pulse of MIN_US+RATIO_MAX us. Any larger value clamps to that width.

Optional Feature:
- Macro: ESC_SLEW_LIMIT_EN.
- Defined: in ARMED, each boundary moves sh_n toward the clamped input by at most SLEW_STEP per frame, saturating at the target. Entering ARMED starts from sh_n=0.
- Undefined: sh_n takes the clamped input directly. The SLEW_STEP parameter remains present but is unused.

Decomposition:
- Shared package esc_pkg contains:
  - state typedef {DISARMED, ARMING, ARMED};
  - default constants for CLK_PER_US, FRAME_US, MIN_US and RATIO_MAX;
  - the 11-bit ratio typedef shared with the stabiliser block.
- Sub-module esc_pwm_channel, instantiated ×4, contains the clamp, the optional slew, the shadow register and the pulse comparator.
- The top level holds the prescaler, frame counter and arming FSM.
- Parameters may be reduced for simulation (for example CLK_PER_US=2, FRAME_US=200, MIN_US=50, RATIO_MAX=100, ARM_FRAMES=3).

Test Plan:
- Reset: assert rst=0 mid-pulse -> all pwm low within the same clk; armed=0 and frame_start=0 until released.
- Arming: arm_req=1 at default parameters -> 100 frames with pwm high for 50000 clks each, then armed=1 at the 101st boundary.
- Width mapping, ARMED:
  - m1ratio=500 -> pwm1 high for 75000 clks per 1000000-clk frame.
  - m2ratio=0 -> pwm2 high for 50000 clks.
  - m3ratio=1500 -> pwm3 high for 100000 clks (clamped).
- Mid-frame change: m1ratio 200->800 at frame_us=5000 -> current pulse 1200 us, next pulse 1800 us.
- Disarm: arm_req 1->0 at frame_us=100 while pwm4 is high -> pulse completes at full width, armed falls at the boundary, next frame has no pulses.
- ESC_SLEW_LIMIT_EN: step m1ratio 0->100 in ARMED -> successive widths 1020, 1040, 1060, 1080, 1100 us, then steady at 1100 us.
